// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parameterised FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through reads
// (rd_data shows the head word combinationally; 0 while empty). Without it,
// reads are registered: rd_data loads one edge after an accepted read and
// holds until the next accepted read.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   wr_en/wr_data  write request and data (dropped while full)
//   rd_en/rd_data  read request and data (ignored while empty)
//   full, almost_full, empty, almost_empty, count   occupancy status
//   overflow, underflow  sticky error flags, cleared by err_clr
//   err_clr        synchronous clear; a same-cycle violation wins
module sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    empty,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LEVEL);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;

  // Pointers carry one extra wrap bit so full (diff == DEPTH) and empty
  // (diff == 0) are distinguishable; modulo subtraction gives occupancy.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Acceptance uses pre-edge status only; a read cannot free space for a
  // same-cycle write when full, nor can a write feed a read when empty.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Set term ORed after the clear so a violation concurrent with err_clr
  // leaves the flag asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_q <= '0;
    else if (rd_acc) rd_q <= mem[rd_ptr[AW-1:0]];
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, DATA_WIDTH=8). Compile with
// SYNC_FIFO_FWFT_EN defined to exercise the fall-through read build.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1; step(); rd_en = 1'b0;
`else
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(exp));
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
    chk({tag, "_rdata"}, 32'(rd_data), 32'd0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    #12;
    chk_reset_state("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset mid-traffic with count=5 (after one read, count 4 then refill to 5).
    for (int i = 1; i <= 5; i++) push(DW'(i));
    chk("mid_count5", 32'(count), 32'd5);
    pop_check("mid_pop1", 8'h01);
    push(8'h06);
    chk("mid_count5b", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    push(8'h11);
    chk("post_rst_count", 32'(count), 32'd1);
    pop_check("post_rst_data", 8'h11);
    chk("post_rst_empty", 32'(empty), 32'd1);

    // Fill, threshold flags, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      push(DW'(i));
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill_aempty", 32'(almost_empty), 32'(i + 1 <= 2));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    push(8'hAA);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) pop_check("drain", DW'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_unf", 32'(underflow), 32'd0);
    clear_err();
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous read and write: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) push(DW'(i));
`ifdef SYNC_FIFO_FWFT_EN
    chk("frw_head", 32'(rd_data), 32'h00);
`endif
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hBB;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk("frw_rdata", 32'(rd_data), 32'h00);
`endif
    chk("frw_ovf", 32'(overflow), 32'd1);
    chk("frw_count", 32'(count), 32'd15);
    for (int i = 1; i < DEPTH; i++) pop_check("frw_drain", DW'(i));
    chk("frw_empty", 32'(empty), 32'd1);
    clear_err();

    // Underflow: rejected read leaves data and count alone.
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("unf_rdata", 32'(rd_data), 32'h00);
`else
    chk("unf_rdata", 32'(rd_data), 32'h0F);
`endif
    clear_err();
    chk("unf_clr", 32'(underflow), 32'd0);
    err_clr = 1'b1; rd_en = 1'b1; step(); err_clr = 1'b0; rd_en = 1'b0;
    chk("unf_clr_vs_set", 32'(underflow), 32'd1);
    clear_err();
    chk("unf_clr2", 32'(underflow), 32'd0);

    // Streaming across pointer wrap at constant occupancy 8.
    for (int i = 0; i < 8; i++) push(DW'(8'h20 + i));
    for (int k = 0; k < 40; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("stream_data", 32'(rd_data), 32'(8'h20 + k));
`endif
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(8'h28 + k);
      step();
`ifndef SYNC_FIFO_FWFT_EN
      chk("stream_data", 32'(rd_data), 32'(8'h20 + k));
`endif
      chk("stream_count", 32'(count), 32'd8);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("stream_ovf", 32'(overflow), 32'd0);
    chk("stream_unf", 32'(underflow), 32'd0);
    chk("stream_full", 32'(full), 32'd0);
    chk("stream_afull", 32'(almost_full), 32'd0);
    chk("stream_aempty", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 8; i++) pop_check("stream_tail", DW'(8'h48 + i));
    chk("stream_empty", 32'(empty), 32'd1);

    // Read-mode latency.
    push(8'h5A);
    chk("rm_empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rm_fwft_early", 32'(rd_data), 32'h5A);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rm_fwft_after", 32'(rd_data), 32'h00);
`else
    chk("rm_reg_hold", 32'(rd_data), 32'h4F);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rm_reg_data", 32'(rd_data), 32'h5A);
    step();
    chk("rm_reg_keep", 32'(rd_data), 32'h5A);
`endif
    chk("rm_final_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
